regfile_port_arbiter: RTL and testbench

//   Shares the single read/write port pair of the 32x32 register file between two

---
 rtl/regfile_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the register file's single read/write port pair
// between requester q0 (integer side) and q1 (FP side). One operation every three
// cycles: accept (IDLE) -> strobe (ISSUE) -> completion pulse (RESP).
// Optional feature: define REGARB_R0_LOCK_EN to make r0 read-only (writes to r0
// are acknowledged but never strobed into the register file).
module regfile_port_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              q0_valid,
  output logic              q0_ready,
  input  logic              q0_we,
  input  logic [ADDR_W-1:0] q0_rs1,
  input  logic [ADDR_W-1:0] q0_rs2,
  input  logic [ADDR_W-1:0] q0_ws,
  input  logic [DATA_W-1:0] q0_wd,
  output logic              q0_rsp_valid,
  output logic [DATA_W-1:0] q0_rd1,
  output logic [DATA_W-1:0] q0_rd2,
  // requester 1
  input  logic              q1_valid,
  output logic              q1_ready,
  input  logic              q1_we,
  input  logic [ADDR_W-1:0] q1_rs1,
  input  logic [ADDR_W-1:0] q1_rs2,
  input  logic [ADDR_W-1:0] q1_ws,
  input  logic [DATA_W-1:0] q1_wd,
  output logic              q1_rsp_valid,
  output logic [DATA_W-1:0] q1_rd1,
  output logic [DATA_W-1:0] q1_rd2,
  // register file side
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  output logic [ADDR_W-1:0] rf_ws,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_rf,
  output logic              rf_wf,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   rf_rs1_q, rf_rs1_d;
  logic [ADDR_W-1:0]   rf_rs2_q, rf_rs2_d;
  logic [ADDR_W-1:0]   rf_ws_q, rf_ws_d;
  logic [DATA_W-1:0]   rf_wd_q, rf_wd_d;
  logic                rf_rf_q, rf_rf_d;
  logic                rf_wf_q, rf_wf_d;
  logic                q0_rsp_q, q0_rsp_d;
  logic                q1_rsp_q, q1_rsp_d;
  logic [DATA_W-1:0]   q0_rd1_q, q0_rd1_d;
  logic [DATA_W-1:0]   q0_rd2_q, q0_rd2_d;
  logic [DATA_W-1:0]   q1_rd1_q, q1_rd1_d;
  logic [DATA_W-1:0]   q1_rd2_q, q1_rd2_d;

  logic                accept;
  logic                winner;
  logic                sel_we;
  logic                sel_wr_ok;
  logic [ADDR_W-1:0]   sel_rs1;
  logic [ADDR_W-1:0]   sel_rs2;
  logic [ADDR_W-1:0]   sel_ws;
  logic [DATA_W-1:0]   sel_wd;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    accept  = (state_q == StIdle) && (q0_valid || q1_valid);
    winner  = (q0_valid && q1_valid) ? ~last_grant_q : q1_valid;
    sel_we  = winner ? q1_we  : q0_we;
    sel_rs1 = winner ? q1_rs1 : q0_rs1;
    sel_rs2 = winner ? q1_rs2 : q0_rs2;
    sel_ws  = winner ? q1_ws  : q0_ws;
    sel_wd  = winner ? q1_wd  : q0_wd;
`ifdef REGARB_R0_LOCK_EN
    sel_wr_ok = sel_we && (sel_ws != '0);
`else
    sel_wr_ok = sel_we;
`endif
    q0_ready = accept && !winner;
    q1_ready = accept && winner;
  end

  // Next-state: latch the granted request, pulse one strobe, then ack the owner.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    rf_rs1_d     = rf_rs1_q;
    rf_rs2_d     = rf_rs2_q;
    rf_ws_d      = rf_ws_q;
    rf_wd_d      = rf_wd_q;
    rf_rf_d      = 1'b0;
    rf_wf_d      = 1'b0;
    q0_rsp_d     = 1'b0;
    q1_rsp_d     = 1'b0;
    q0_rd1_d     = q0_rd1_q;
    q0_rd2_d     = q0_rd2_q;
    q1_rd1_d     = q1_rd1_q;
    q1_rd2_d     = q1_rd2_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StIssue;
          owner_d      = winner;
          last_grant_d = winner;
          we_d         = sel_we;
          rf_rs1_d     = sel_rs1;
          rf_rs2_d     = sel_rs2;
          rf_ws_d      = sel_ws;
          rf_wd_d      = sel_wd;
          rf_rf_d      = !sel_we;
          rf_wf_d      = sel_wr_ok;
        end
      end
      StIssue: begin
        state_d = StResp;
        if (owner_q) q1_rsp_d = 1'b1;
        else         q0_rsp_d = 1'b1;
        // Register file is combinational, so read data is valid during ISSUE.
        if (!we_q) begin
          if (owner_q) begin
            q1_rd1_d = rf_rd1;
            q1_rd2_d = rf_rd2;
          end else begin
            q0_rd1_d = rf_rd1;
            q0_rd2_d = rf_rd2;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      rf_rs1_q     <= '0;
      rf_rs2_q     <= '0;
      rf_ws_q      <= '0;
      rf_wd_q      <= '0;
      rf_rf_q      <= 1'b0;
      rf_wf_q      <= 1'b0;
      q0_rsp_q     <= 1'b0;
      q1_rsp_q     <= 1'b0;
      q0_rd1_q     <= '0;
      q0_rd2_q     <= '0;
      q1_rd1_q     <= '0;
      q1_rd2_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      rf_rs1_q     <= rf_rs1_d;
      rf_rs2_q     <= rf_rs2_d;
      rf_ws_q      <= rf_ws_d;
      rf_wd_q      <= rf_wd_d;
      rf_rf_q      <= rf_rf_d;
      rf_wf_q      <= rf_wf_d;
      q0_rsp_q     <= q0_rsp_d;
      q1_rsp_q     <= q1_rsp_d;
      q0_rd1_q     <= q0_rd1_d;
      q0_rd2_q     <= q0_rd2_d;
      q1_rd1_q     <= q1_rd1_d;
      q1_rd2_q     <= q1_rd2_d;
    end
  end

  assign rf_rs1       = rf_rs1_q;
  assign rf_rs2       = rf_rs2_q;
  assign rf_ws        = rf_ws_q;
  assign rf_wd        = rf_wd_q;
  assign rf_rf        = rf_rf_q;
  assign rf_wf        = rf_wf_q;
  assign q0_rsp_valid = q0_rsp_q;
  assign q1_rsp_valid = q1_rsp_q;
  assign q0_rd1       = q0_rd1_q;
  assign q0_rd2       = q0_rd2_q;
  assign q1_rd1       = q1_rd1_q;
  assign q1_rd2       = q1_rd2_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed scenarios followed by
// randomized requests, compared against a transaction-level reference model.
module tb_regfile_port_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef REGARB_R0_LOCK_EN
  localparam bit Lock = 1'b1;
`else
  localparam bit Lock = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          q0_valid, q0_ready, q0_we, q0_rsp_valid;
  logic [AW-1:0] q0_rs1, q0_rs2, q0_ws;
  logic [DW-1:0] q0_wd, q0_rd1, q0_rd2;
  logic          q1_valid, q1_ready, q1_we, q1_rsp_valid;
  logic [AW-1:0] q1_rs1, q1_rs2, q1_ws;
  logic [DW-1:0] q1_wd, q1_rd1, q1_rd2;
  logic [AW-1:0] rf_rs1, rf_rs2, rf_ws;
  logic [DW-1:0] rf_wd, rf_rd1, rf_rd2;
  logic          rf_rf, rf_wf;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .q0_valid(q0_valid), .q0_ready(q0_ready), .q0_we(q0_we), .q0_rs1(q0_rs1),
    .q0_rs2(q0_rs2), .q0_ws(q0_ws), .q0_wd(q0_wd), .q0_rsp_valid(q0_rsp_valid),
    .q0_rd1(q0_rd1), .q0_rd2(q0_rd2),
    .q1_valid(q1_valid), .q1_ready(q1_ready), .q1_we(q1_we), .q1_rs1(q1_rs1),
    .q1_rs2(q1_rs2), .q1_ws(q1_ws), .q1_wd(q1_wd), .q1_rsp_valid(q1_rsp_valid),
    .q1_rd1(q1_rd1), .q1_rd2(q1_rd2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_ws(rf_ws), .rf_wd(rf_wd),
    .rf_rf(rf_rf), .rf_wf(rf_wf), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  // Preloaded register contents (r0=1.0, r1=9.0, r2=40.5, r5=492.075).
  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      0:       return 32'h3F80_0000;
      1:       return 32'h4110_0000;
      2:       return 32'h4222_0000;
      5:       return 32'h43F6_099A;
      default: return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endcase
  endfunction

  // Combinational-read register file stand-in, loaded on the first clock edge.
  logic [DW-1:0] rf_mem [32];
  logic          rf_loaded = 1'b0;
  assign rf_rd1 = rf_mem[rf_rs1];
  assign rf_rd2 = rf_mem[rf_rs2];
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      rf_loaded <= 1'b1;
    end else if (rf_wf) begin
      rf_mem[rf_ws] <= rf_wd;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [32];
  int            m_last;
  logic [DW-1:0] m_rd1 [2];
  logic [DW-1:0] m_rd2 [2];
  int            last_owner;

  // Per-round request settings.
  logic          d_valid [2];
  logic          d_we [2];
  logic [AW-1:0] d_rs1 [2];
  logic [AW-1:0] d_rs2 [2];
  logic [AW-1:0] d_ws [2];
  logic [DW-1:0] d_wd [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic apply();
    q0_valid = d_valid[0]; q0_we = d_we[0]; q0_rs1 = d_rs1[0]; q0_rs2 = d_rs2[0];
    q0_ws = d_ws[0]; q0_wd = d_wd[0];
    q1_valid = d_valid[1]; q1_we = d_we[1]; q1_rs1 = d_rs1[1]; q1_rs2 = d_rs2[1];
    q1_ws = d_ws[1]; q1_wd = d_wd[1];
  endtask

  // Fields only need to hold in the accept cycle; garble them afterwards.
  task automatic scramble();
    q0_we = 1'($urandom_range(1)); q0_rs1 = AW'($urandom_range(31));
    q0_rs2 = AW'($urandom_range(31)); q0_ws = AW'($urandom_range(31)); q0_wd = $urandom();
    q1_we = 1'($urandom_range(1)); q1_rs1 = AW'($urandom_range(31));
    q1_rs2 = AW'($urandom_range(31)); q1_ws = AW'($urandom_range(31)); q1_wd = $urandom();
  endtask

  task automatic clear_req();
    for (int p = 0; p < 2; p++) begin
      d_valid[p] = 1'b0; d_we[p] = 1'b0; d_rs1[p] = '0; d_rs2[p] = '0;
      d_ws[p] = '0; d_wd[p] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_req();
    apply();
    repeat (2) @(negedge clk);
    check_eq("rst_ready0", 32'(q0_ready), 32'd0);
    check_eq("rst_ready1", 32'(q1_ready), 32'd0);
    check_eq("rst_rsp0", 32'(q0_rsp_valid), 32'd0);
    check_eq("rst_rsp1", 32'(q1_rsp_valid), 32'd0);
    check_eq("rst_rf", 32'(rf_rf), 32'd0);
    check_eq("rst_wf", 32'(rf_wf), 32'd0);
    check_eq("rst_buses", 32'({rf_rs1, rf_rs2, rf_ws}), 32'd0);
    check_eq("rst_wd", rf_wd, 32'd0);
    check_eq("rst_rd", q0_rd1 | q0_rd2 | q1_rd1 | q1_rd2, 32'd0);
    m_last = 1;
    for (int p = 0; p < 2; p++) begin
      m_rd1[p] = '0;
      m_rd2[p] = '0;
    end
    rst_n = 1'b1;
  endtask

  // One arbitration round: idle cycle, or accept -> issue -> response.
  task automatic round();
    int            own;
    logic          exp_wf;
    logic          e_we;
    logic [AW-1:0] e_rs1, e_rs2, e_ws;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    apply();
    #1;
    if (!d_valid[0] && !d_valid[1]) begin
      check_eq("idle_ready0", 32'(q0_ready), 32'd0);
      check_eq("idle_ready1", 32'(q1_ready), 32'd0);
      @(negedge clk);
      check_eq("idle_rsp", 32'({q0_rsp_valid, q1_rsp_valid}), 32'd0);
      check_eq("idle_strobe", 32'({rf_rf, rf_wf}), 32'd0);
      last_owner = -1;
      return;
    end
    if (d_valid[0] && d_valid[1]) own = (m_last == 1) ? 0 : 1;
    else                          own = d_valid[1] ? 1 : 0;
    m_last = own;
    last_owner = own;
    check_eq("accept_ready0", 32'(q0_ready), 32'(own == 0));
    check_eq("accept_ready1", 32'(q1_ready), 32'(own == 1));
    e_we = d_we[own]; e_rs1 = d_rs1[own]; e_rs2 = d_rs2[own];
    e_ws = d_ws[own]; e_wd = d_wd[own];
    exp_wf = e_we && !(Lock && e_ws == '0);
    if (e_we) begin
      if (exp_wf) ref_mem[e_ws] = e_wd;
    end else begin
      m_rd1[own] = ref_mem[e_rs1];
      m_rd2[own] = ref_mem[e_rs2];
    end
    @(negedge clk);
    scramble();
    #1;
    check_eq("issue_rf", 32'(rf_rf), 32'(!e_we));
    check_eq("issue_wf", 32'(rf_wf), 32'(exp_wf));
    if (e_we) begin
      check_eq("issue_ws", 32'(rf_ws), 32'(e_ws));
      check_eq("issue_wd", rf_wd, e_wd);
    end else begin
      check_eq("issue_rs", 32'({rf_rs1, rf_rs2}), 32'({e_rs1, e_rs2}));
    end
    check_eq("issue_ready", 32'({q0_ready, q1_ready}), 32'd0);
    check_eq("issue_rsp", 32'({q0_rsp_valid, q1_rsp_valid}), 32'd0);
    @(negedge clk);
    #1;
    check_eq("resp_rsp0", 32'(q0_rsp_valid), 32'(own == 0));
    check_eq("resp_rsp1", 32'(q1_rsp_valid), 32'(own == 1));
    check_eq("resp_q0_rd1", q0_rd1, m_rd1[0]);
    check_eq("resp_q0_rd2", q0_rd2, m_rd2[0]);
    check_eq("resp_q1_rd1", q1_rd1, m_rd1[1]);
    check_eq("resp_q1_rd2", q1_rd2, m_rd2[1]);
    check_eq("resp_strobe", 32'({rf_rf, rf_wf}), 32'd0);
    check_eq("resp_ready", 32'({q0_ready, q1_ready}), 32'd0);
    check_eq("resp_hold_ws", 32'(rf_ws), 32'(e_ws));
  endtask

  initial begin
    int seq [4];
    seq = '{0, 1, 0, 1};
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    last_owner = -1;

    // Reset state.
    do_reset();

    // Lone read of r1/r2 by q0.
    clear_req();
    d_valid[0] = 1'b1; d_rs1[0] = 5'd1; d_rs2[0] = 5'd2;
    round();
    check_eq("t2_rd1", q0_rd1, 32'h4110_0000);
    check_eq("t2_rd2", q0_rd2, 32'h4222_0000);

    // Both valid from reset: strict alternation starting with q0.
    do_reset();
    clear_req();
    d_valid[0] = 1'b1; d_valid[1] = 1'b1;
    d_rs1[0] = 5'd3; d_rs2[0] = 5'd4; d_rs1[1] = 5'd6; d_rs2[1] = 5'd6;
    for (int i = 0; i < 4; i++) begin
      round();
      check_eq("t3_grant", 32'(last_owner), 32'(seq[i]));
    end

    // q1 writes r20, q0 reads it back.
    clear_req();
    d_valid[1] = 1'b1; d_we[1] = 1'b1; d_ws[1] = 5'd20; d_wd[1] = 32'hDEAD_BEEF;
    round();
    clear_req();
    d_valid[0] = 1'b1; d_rs1[0] = 5'd20; d_rs2[0] = 5'd1;
    round();
    check_eq("t4_rd1", q0_rd1, 32'hDEAD_BEEF);

    // Write to r0, then read it back.
    clear_req();
    d_valid[0] = 1'b1; d_we[0] = 1'b1; d_ws[0] = 5'd0; d_wd[0] = 32'h0;
    round();
    clear_req();
    d_valid[0] = 1'b1; d_rs1[0] = 5'd0; d_rs2[0] = 5'd0;
    round();
    check_eq("t5_r0", q0_rd1, Lock ? 32'h3F80_0000 : 32'h0);

    // Reset during ISSUE of a write to r5 discards it.
    do_reset();
    clear_req();
    @(negedge clk);
    q0_valid = 1'b1; q0_we = 1'b1; q0_ws = 5'd5; q0_wd = 32'h1234_5678;
    #1;
    check_eq("t6_ready", 32'(q0_ready), 32'd1);
    @(negedge clk);
    q0_valid = 1'b0;
    #1;
    check_eq("t6_wf_issue", 32'(rf_wf), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_wf_drop", 32'(rf_wf), 32'd0);
    @(negedge clk);
    check_eq("t6_no_rsp", 32'({q0_rsp_valid, q1_rsp_valid}), 32'd0);
    do_reset();
    clear_req();
    d_valid[0] = 1'b1; d_rs1[0] = 5'd5; d_rs2[0] = 5'd5;
    round();
    check_eq("t6_r5", q0_rd1, 32'h43F6_099A);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      for (int p = 0; p < 2; p++) begin
        d_valid[p] = ($urandom_range(9) < 7);
        d_we[p]    = 1'($urandom_range(1));
        d_rs1[p]   = AW'($urandom_range(31));
        d_rs2[p]   = AW'($urandom_range(31));
        d_ws[p]    = AW'($urandom_range(31));
        d_wd[p]    = $urandom();
      end
      round();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
